vga_scan_gen: RTL and testbench
===============================

Name: vga_scan_gen

Overview:
- Produces the raster scan every sprite and membrane block consumes: `h_cnt`, `v_cnt`, the once-per-frame `frame` strobe, and VGA `hsync`/`vsync`/`video_on`.
- Sits at top level. It is driven by the 100 MHz board clock and divides it down to a pixel-rate enable.
- Molecule blocks compare their position against `h_cnt`/`v_cnt` and step their motion on `frame`. This block is the producer end of that interface.

Parameters:
- PIX_DIV, 4, board clocks per pixel; legal range 1..16.
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.

Ports:
- clk  in  1  board clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- p_tick  out  1  pixel enable; one clk wide, once every PIX_DIV clks.
- h_cnt  out  10  horizontal position, 0..H_TOTAL-1 (H_TOTAL = 800).
- v_cnt  out  10  vertical position, 0..V_TOTAL-1 (V_TOTAL = 525).
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  high while (h_cnt, v_cnt) is inside the visible area.
- frame  out  1  one-clk strobe at the start of vertical blank.

Behaviour:
- Clocking and reset: single clock domain. `reset` is synchronous and active-high. All state changes happen on the rising edge of `clk`.
- Reset values (reset sampled high):
  - divider = 0, `p_tick` = 0 (`p_tick` is held 1 throughout when PIX_DIV = 1).
  - `h_cnt` = 0, `v_cnt` = 0.
  - `hsync` = 1, `vsync` = 1, `frame` = 0.
  - `video_on` = 1, derived combinationally from the reset counters.
- Pixel divider:
  - Counts 0..PIX_DIV-1 and wraps.
  - `p_tick` is high while divider == PIX_DIV-1.
  - The first `p_tick` is in the 4th clk after reset deasserts (PIX_DIV = 4).
- Horizontal counter: advances only on edges where `p_tick` = 1. At H_TOTAL-1 (799) it wraps to 0.
- Vertical counter:
  - Increments on the same edge where `h_cnt` wraps.
  - At V_TOTAL-1 (524) it wraps to 0, on the same edge that `h_cnt` wraps 799→0.
- hsync/vsync:
  - Registered. They update on the same edge as the counters, so they always correspond to the current `h_cnt`/`v_cnt`.
  - `hsync` = 0 iff `h_cnt` is in [656, 751].
  - `vsync` = 0 iff `v_cnt` is in [490, 491].
  - No one-cycle pipeline skew relative to the counters is permitted.
- video_on = (`h_cnt` < H_VISIBLE) & (`v_cnt` < V_VISIBLE). Combinational from the registered counters.
- frame:
  - Registered. Set to 1 on the edge where the counters become (0, V_VISIBLE) = (0, 480).
  - Cleared on the next clk edge, giving exactly one clk per frame.
  - Sprite state therefore moves only during blank, and never tears mid-frame.
- Frame period: H_TOTAL × V_TOTAL × PIX_DIV = 800 × 525 × 4 = 1,680,000 clks.
- Reset mid-frame: all state returns to reset values on the next edge. No partial `frame` pulse is emitted. Counting restarts from (0, 0).
- Boundary conditions:
  - (799, 524) wraps to (0, 0) in a single tick.
  - `frame` never fires at (0, 0).
  - Counters never exceed H_TOTAL-1 or V_TOTAL-1.
- Width rule: H_TOTAL and V_TOTAL must fit in 10 bits. Checked by an elaboration-time assertion.

Decomposition:
- Package `vga_scan_pkg`:
  - Default timing constants.
  - Derived values: H_TOTAL, V_TOTAL, HS_START = H_VISIBLE + H_FP, HS_END = HS_START + H_SYNC - 1, and the V equivalents.
  - A 10-bit coordinate typedef shared with the molecule blocks.
- One sub-module, `pixel_tick_gen`: the PIX_DIV divider, producing `p_tick`. Counters and sync logic stay in the top module.

Test Plan:
- Reset: hold `reset` for 3 clks, then release → `h_cnt` = 0, `v_cnt` = 0, `hsync` = 1, `vsync` = 1, `frame` = 0, `video_on` = 1. First `p_tick` in clk 4 after release; ticks then every 4 clks.
- Line timing:
  - Run one line → `h_cnt` steps 0..799 and wraps to 0 while `v_cnt` goes 0→1.
  - `hsync` falls when `h_cnt` becomes 656 and rises when it becomes 752, giving 96 ticks low.
  - `video_on` falls when `h_cnt` becomes 640.
- Frame timing:
  - Run 2 frames → `frame` is high exactly one clk each time, at (0, 480).
  - Pulse spacing is 1,680,000 clks.
  - `vsync` is low for lines 490–491 only (1600 ticks).
- Wrap corner: at (799, 524) the next tick → (0, 0). `hsync` = 1, `vsync` = 1, `frame` = 0.
- Mid-frame reset: assert `reset` for 1 clk at (300, 479) with `p_tick` high → (0, 0) on the next edge. `frame` is not pulsed. The next `frame` arrives 480 × 800 × 4 clks later.
- PIX_DIV = 1 build: `p_tick` is constantly 1 after reset. Frame period is 420,000 clks.

Source files
------------

// File: rtl/vga_scan_pkg.sv
// Shared raster timing constants and the coordinate type used by the scan
// generator and every block that consumes its h_cnt/v_cnt.
package vga_scan_pkg;

  localparam int unsigned DEF_PIX_DIV   = 4;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned DEF_H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned COORD_RANGE = 1024;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_gen_pixel_tick_gen.sv
// Divides the board clock down to a one-clk pixel enable every PIX_DIV clks;
// with PIX_DIV = 1 the enable is permanently high.
module pixel_tick_gen
  import vga_scan_pkg::*;
#(
  parameter int unsigned PIX_DIV = DEF_PIX_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  if ((PIX_DIV < 1) || (PIX_DIV > 16)) begin : g_bad_div
    $error("pixel_tick_gen: PIX_DIV must be within 1..16");
  end

  logic [3:0] div_q;
  logic [3:0] div_d;

  // Divider wraps after reaching DIV_LAST
  always_comb begin
    div_d = div_q + 4'd1;
    if (div_q == DIV_LAST) begin
      div_d = 4'd0;
    end else begin
      div_d = div_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan producer: pixel/line counters, registered syncs aligned with the
// counters, and a one-clk frame strobe at the start of vertical blank.
module vga_scan_gen
  import vga_scan_pkg::*;
#(
  parameter int unsigned PIX_DIV   = DEF_PIX_DIV,
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP
) (
  input  logic   clk,
  input  logic   reset,
  output logic   p_tick,
  output coord_t h_cnt,
  output coord_t v_cnt,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on,
  output logic   frame
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  if ((H_TOTAL > COORD_RANGE) || (V_TOTAL > COORD_RANGE)) begin : g_bad_width
    $error("vga_scan_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
  end

  pixel_tick_gen #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   frame_q, frame_d;

  // Syncs and frame are computed from the next counter values so they land
  // on the same edge as the counters they describe.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (p_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end
    hsync_d = ~in_window(h_cnt_d, HS_START, HS_END);
    vsync_d = ~in_window(v_cnt_d, VS_START, VS_END);
    frame_d = p_tick & (h_cnt_d == 10'd0) & (v_cnt_d == V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_q <= frame_d;
    end
  end

  assign h_cnt    = h_cnt_q;
  assign v_cnt    = v_cnt_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign frame    = frame_q;
  assign video_on = (h_cnt_q < H_VIS) & (v_cnt_q < V_VIS);

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench: two reduced-raster instances (PIX_DIV 4 and 1) compared
// every cycle against an arithmetic model driven by clocks-since-reset.
module tb_vga_scan_gen;

  localparam int P4 = 4;
  localparam int HV = 16, HFP = 2, HSY = 3, HBP = 2;
  localparam int VV = 8,  VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HV + HFP + HSY + HBP;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int HS0 = HV + HFP, HS1 = HV + HFP + HSY - 1;
  localparam int VS0 = VV + VFP, VS1 = VV + VFP + VSY - 1;
  localparam int FRAME4 = HT * VT * P4;

  logic clk = 1'b0;
  logic reset;
  logic       tk4, hs4, vs4, vo4, fr4;
  logic [9:0] h4, v4;
  logic       tk1, hs1, vs1, vo1, fr1;
  logic [9:0] h1, v1;

  int tests = 0;
  int fails = 0;
  int c = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vga_scan_gen #(.PIX_DIV(P4), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                 .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut (
    .clk(clk), .reset(reset), .p_tick(tk4), .h_cnt(h4), .v_cnt(v4),
    .hsync(hs4), .vsync(vs4), .video_on(vo4), .frame(fr4));

  vga_scan_gen #(.PIX_DIV(1), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                 .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut1 (
    .clk(clk), .reset(reset), .p_tick(tk1), .h_cnt(h1), .v_cnt(v1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .frame(fr1));

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d (clk %0d)", tag, got, exp, c);
    end
  endtask

  // Pixel position (within one frame) after c clocks of running at divide p.
  function automatic int pos_of(input int cc, input int p);
    return (cc / p) % (HT * VT);
  endfunction

  task automatic check_model(input string pfx, input int p, input logic tk,
                             input logic [9:0] h, input logic [9:0] v,
                             input logic hs, input logic vs, input logic vo, input logic fr);
    int pos, eh, ev;
    pos = pos_of(c, p);
    eh  = pos % HT;
    ev  = pos / HT;
    check_eq({pfx, "p_tick"},   32'(tk), 32'((c % p) == p - 1));
    check_eq({pfx, "h_cnt"},    32'(h),  eh);
    check_eq({pfx, "v_cnt"},    32'(v),  ev);
    check_eq({pfx, "hsync"},    32'(hs), 32'(!(eh >= HS0 && eh <= HS1)));
    check_eq({pfx, "vsync"},    32'(vs), 32'(!(ev >= VS0 && ev <= VS1)));
    check_eq({pfx, "video_on"}, 32'(vo), 32'(eh < HV && ev < VV));
    check_eq({pfx, "frame"},    32'(fr), 32'((c % p) == 0 && pos == VV * HT));
  endtask

  always @(posedge clk) begin
    if (reset) c <= 0;
    else       c <= c + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_model("d4_", P4, tk4, h4, v4, hs4, vs4, vo4, fr4);
      check_model("d1_", 1,  tk1, h1, v1, hs1, vs1, vo1, fr1);
    end
  end

  task automatic wait_pos(input int target, input string tag);
    int n;
    n = 0;
    while (!(pos_of(c, P4) == target && (c % P4) == P4 - 1) && n < 2 * FRAME4) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME4) check_eq({tag, "_timeout"}, n, 0);
  endtask

  initial begin
    int k, n, hs_lo, vs_lo, vid, fr_hi, fr1_cnt, hs1_lo;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    check_eq("rst_h_cnt", 32'(h4), 0);
    check_eq("rst_v_cnt", 32'(v4), 0);
    check_eq("rst_hsync", 32'(hs4), 1);
    check_eq("rst_vsync", 32'(vs4), 1);
    check_eq("rst_frame", 32'(fr4), 0);
    check_eq("rst_video_on", 32'(vo4), 1);
    check_eq("rst_p_tick", 32'(tk4), 0);
    check_eq("rst_p_tick_div1", 32'(tk1), 1);

    k = 0;
    while (!tk4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("first_tick_delay", k, P4 - 1);

    n = 0;
    while (!fr4 && n < 2 * FRAME4) begin
      @(negedge clk);
      n++;
    end
    check_eq("first_frame_clk", c, VV * HT * P4);

    // One full frame window between consecutive strobes
    n = 0; hs_lo = 0; vs_lo = 0; vid = 0; fr_hi = 0; fr1_cnt = 0; hs1_lo = 0;
    do begin
      @(negedge clk);
      n++;
      hs_lo   += 32'(!hs4);
      vs_lo   += 32'(!vs4);
      vid     += 32'(vo4);
      fr_hi   += 32'(fr4);
      fr1_cnt += 32'(fr1);
      hs1_lo  += 32'(!hs1);
    end while (!fr4 && n < 2 * FRAME4);
    check_eq("frame_spacing", n, FRAME4);
    check_eq("frame_high_clks", fr_hi, 1);
    check_eq("hsync_low_clks", hs_lo, VT * HSY * P4);
    check_eq("vsync_low_clks", vs_lo, VSY * HT * P4);
    check_eq("video_on_clks", vid, VV * HV * P4);
    check_eq("div1_frames_per_window", fr1_cnt, P4);
    check_eq("div1_hsync_low_clks", hs1_lo, P4 * VT * HSY);

    wait_pos(HT * VT - 1, "wrap");
    @(negedge clk);
    check_eq("wrap_h_cnt", 32'(h4), 0);
    check_eq("wrap_v_cnt", 32'(v4), 0);
    check_eq("wrap_hsync", 32'(hs4), 1);
    check_eq("wrap_vsync", 32'(vs4), 1);
    check_eq("wrap_frame", 32'(fr4), 0);

    wait_pos((VV - 1) * HT + 5, "midreset");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_h_cnt", 32'(h4), 0);
    check_eq("midrst_v_cnt", 32'(v4), 0);
    check_eq("midrst_frame", 32'(fr4), 0);
    n = 0;
    while (!fr4 && n < 2 * FRAME4) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrst_next_frame", n, VV * HT * P4);

    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 2 * FRAME4)) @(negedge clk);
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      reset = 1'b0;
    end
    repeat (HT * P4 * 2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
